// File: rtl/uart_rx_io.sv
// 8N1 serial receiver with 16x oversampling and a byte FIFO, read over the J1 io bus.
// Data reads pop the FIFO head; status reads return {ferr, ovf, ~empty} and clear the sticky flags.
module uart_rx_io #(
   parameter int          CLKFREQ    = 12000000,
   parameter int          BAUD       = 9600,
   parameter int          DEPTH_LOG2 = 4,
   parameter logic [15:0] ADDR_DATA  = 16'h1000,
   parameter logic [15:0] ADDR_STAT  = 16'h2000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   input  logic        io_rd,
   input  logic [15:0] mem_addr,
   output logic [15:0] io_din,
   output logic        rx_ready,
   output logic [2:0]  dbg_state
);

   localparam int DIV   = CLKFREQ / (BAUD * 16);
   localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t              state_q, state_d;
   logic                rx_meta_q, rx_s_q;
   logic [DW-1:0]       div_q, div_d;
   logic [3:0]          sc_q, sc_d;
   logic [2:0]          bc_q, bc_d;
   logic [7:0]          shreg_q, shreg_d;
   logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                ovf_q, ovf_d, ferr_q, ferr_d, rx_ready_q, rx_ready_d;
   logic [7:0]          mem_q [DEPTH];
   logic                tick, push, ferr_set;
   logic                empty, full, data_rd, stat_rd, pop, wr_en, ovf_set;

   assign tick = (state_q != S_IDLE) && (div_q == DW'(DIV - 1));

   // Tick divider only runs while a frame is in progress, so every frame starts phase-aligned.
   always_comb begin
      div_d = div_q + DW'(1);
      if (state_q == S_IDLE || tick) div_d = '0;
   end

   always_comb begin
      state_d  = state_q;
      sc_d     = sc_q;
      bc_d     = bc_q;
      shreg_d  = shreg_q;
      push     = 1'b0;
      ferr_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               state_d = S_START;
               sc_d    = 4'd0;
            end
         end
         S_START: begin
            if (tick) begin
               sc_d = sc_q + 4'd1;
               if (sc_q == 4'd7) begin
                  sc_d    = 4'd0;
                  bc_d    = 3'd0;
                  state_d = rx_s_q ? S_IDLE : S_DATA;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               sc_d = sc_q + 4'd1;
               if (sc_q == 4'd15) begin
                  shreg_d = {rx_s_q, shreg_q[7:1]};
                  bc_d    = bc_q + 3'd1;
                  if (bc_q == 3'd7) state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               sc_d = sc_q + 4'd1;
               if (sc_q == 4'd15) begin
                  push     = rx_s_q;
                  ferr_set = ~rx_s_q;
                  state_d  = rx_s_q ? S_IDLE : S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                    (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
   assign data_rd = io_rd && (mem_addr == ADDR_DATA);
   assign stat_rd = io_rd && (mem_addr == ADDR_STAT);
   assign pop     = data_rd && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign wr_en   = push && (!full || pop);
   assign ovf_set = push && full && !pop;

   always_comb begin
      wr_ptr_d   = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, wr_en};
      rd_ptr_d   = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, pop};
      ovf_d      = ovf_set  | (ovf_q  & ~stat_rd);
      ferr_d     = ferr_set | (ferr_q & ~stat_rd);
      rx_ready_d = ~empty;
   end

   always_comb begin
      io_din = 16'h0000;
      if (mem_addr == ADDR_DATA) begin
         if (!empty) io_din = {8'h00, mem_q[rd_ptr_q[DEPTH_LOG2-1:0]]};
      end else if (mem_addr == ADDR_STAT) begin
         io_din = {13'b0, ferr_q, ovf_q, ~empty};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         state_q    <= S_IDLE;
         div_q      <= '0;
         sc_q       <= 4'd0;
         bc_q       <= 3'd0;
         shreg_q    <= 8'h00;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ovf_q      <= 1'b0;
         ferr_q     <= 1'b0;
         rx_ready_q <= 1'b0;
      end else begin
         rx_meta_q  <= rx;
         rx_s_q     <= rx_meta_q;
         state_q    <= state_d;
         div_q      <= div_d;
         sc_q       <= sc_d;
         bc_q       <= bc_d;
         shreg_q    <= shreg_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ovf_q      <= ovf_d;
         ferr_q     <= ferr_d;
         rx_ready_q <= rx_ready_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= shreg_q;
   end

   assign rx_ready  = rx_ready_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_io.sv
// Bench for uart_rx_io: serial frames driven at a fast line rate, received bytes and status
// compared against a queue-based model of the FIFO and its sticky flags.
module tb_uart_rx_io;

   localparam int          CLKFREQ = 3200000;
   localparam int          BAUD    = 100000;
   localparam int          BIT     = CLKFREQ / BAUD;
   localparam int          DEPTH   = 16;
   localparam logic [15:0] A_DATA  = 16'h1000;
   localparam logic [15:0] A_STAT  = 16'h2000;
   localparam logic [2:0]  ST_IDLE = 3'd0;
   localparam logic [2:0]  ST_DATA = 3'd2;

   logic        clk, reset, rx, io_rd, rx_ready;
   logic [15:0] mem_addr, io_din;
   logic [2:0]  dbg_state;

   logic [7:0]  exp_q[$];
   logic        m_ovf, m_ferr;
   int          check_cnt, pass_cnt;

   uart_rx_io #(.CLKFREQ(CLKFREQ), .BAUD(BAUD), .DEPTH_LOG2(4),
                .ADDR_DATA(A_DATA), .ADDR_STAT(A_STAT)) dut (
      .clk(clk), .reset(reset), .rx(rx), .io_rd(io_rd), .mem_addr(mem_addr),
      .io_din(io_din), .rx_ready(rx_ready), .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // All driver tasks start and end on a falling edge.
   task automatic wait_bits(input int n);
      repeat (n * BIT) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_bits);
      rx = 1'b0;
      wait_bits(1);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_bits(1);
      end
      rx = stop_bit;
      wait_bits(stop_bits);
      rx = 1'b1;
      wait_bits(1);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b1, 1);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else m_ovf = 1'b1;
   endtask

   task automatic io_read(input logic [15:0] addr, output logic [15:0] d);
      io_rd    = 1'b1;
      mem_addr = addr;
      #1;
      d = io_din;
      @(negedge clk);
      io_rd    = 1'b0;
      mem_addr = 16'h0000;
   endtask

   function automatic logic [15:0] model_stat();
      return {13'b0, m_ferr, m_ovf, exp_q.size() != 0};
   endfunction

   task automatic test_reset();
      logic [15:0] d;
      check_cnt++;
      if (rx_ready !== 1'b0) $display("FAIL reset_rx_ready: got %b expected 0", rx_ready);
      else pass_cnt++;
      check_cnt++;
      if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
      else pass_cnt++;
      check_cnt++;
      if (io_din !== 16'h0000) $display("FAIL reset_io_din: got %h expected 0000", io_din);
      else pass_cnt++;
      io_read(A_STAT, d);
      check_cnt++;
      if (d !== 16'h0000) $display("FAIL reset_stat: got %h expected 0000", d);
      else pass_cnt++;
      io_read(A_DATA, d);
      check_cnt++;
      if (d !== 16'h0000) $display("FAIL reset_empty_data: got %h expected 0000", d);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      io_read(A_STAT, d);
      check_cnt++;
      if (d !== 16'h0000 || rx_ready !== 1'b0)
         $display("FAIL reset_ptr_unchanged: got stat %h rdy %b expected 0000 0", d, rx_ready);
      else pass_cnt++;
   endtask

   task automatic test_two_bytes();
      logic [15:0] d;
      int          cyc;
      cyc = 0;
      fork
         send_byte(8'h55);
         begin
            while (!rx_ready && cyc < BIT * 12) begin
               @(negedge clk);
               cyc++;
            end
         end
      join
      check_cnt++;
      if (cyc < (BIT * 19) / 2 || cyc > (BIT * 19) / 2 + 8)
         $display("FAIL latency: got %0d clks expected %0d..%0d", cyc, (BIT * 19) / 2, (BIT * 19) / 2 + 8);
      else pass_cnt++;
      send_byte(8'hA3);
      for (int i = 0; i < 2; i++) begin
         io_read(A_DATA, d);
         check_cnt++;
         if (d !== {8'h00, exp_q[0]}) $display("FAIL two_bytes_data%0d: got %h expected %h", i, d, {8'h00, exp_q[0]});
         else pass_cnt++;
         void'(exp_q.pop_front());
      end
      io_read(A_STAT, d);
      check_cnt++;
      if (d !== model_stat()) $display("FAIL two_bytes_stat: got %h expected %h", d, model_stat());
      else pass_cnt++;
   endtask

   task automatic test_overflow();
      logic [15:0] d, e;
      for (int i = 0; i < 17; i++) send_byte(8'(i));
      io_read(A_STAT, d);
      check_cnt++;
      if (d !== model_stat()) $display("FAIL ovf_stat: got %h expected %h", d, model_stat());
      else pass_cnt++;
      m_ovf = 1'b0;
      m_ferr = 1'b0;
      for (int i = 0; i < 16; i++) begin
         io_read(A_DATA, d);
         e = (exp_q.size() != 0) ? {8'h00, exp_q.pop_front()} : 16'h0000;
         check_cnt++;
         if (d !== e) $display("FAIL ovf_data%0d: got %h expected %h", i, d, e);
         else pass_cnt++;
      end
      io_read(A_STAT, d);
      check_cnt++;
      if (d !== model_stat()) $display("FAIL ovf_stat_after: got %h expected %h", d, model_stat());
      else pass_cnt++;
      io_read(A_DATA, d);
      check_cnt++;
      if (d !== 16'h0000) $display("FAIL ovf_drained: got %h expected 0000", d);
      else pass_cnt++;
   endtask

   task automatic test_framing();
      logic [15:0] d;
      send_frame(8'h7E, 1'b0, 3);
      m_ferr = 1'b1;
      check_cnt++;
      if (rx_ready !== 1'b0) $display("FAIL ferr_no_push: got %b expected 0", rx_ready);
      else pass_cnt++;
      send_byte(8'h31);
      io_read(A_STAT, d);
      check_cnt++;
      if (d !== model_stat()) $display("FAIL ferr_stat: got %h expected %h", d, model_stat());
      else pass_cnt++;
      m_ferr = 1'b0;
      m_ovf = 1'b0;
      io_read(A_DATA, d);
      check_cnt++;
      if (d !== {8'h00, exp_q[0]}) $display("FAIL ferr_data: got %h expected %h", d, {8'h00, exp_q[0]});
      else pass_cnt++;
      void'(exp_q.pop_front());
      io_read(A_STAT, d);
      check_cnt++;
      if (d !== model_stat()) $display("FAIL ferr_cleared: got %h expected %h", d, model_stat());
      else pass_cnt++;
   endtask

   task automatic test_glitch();
      logic [15:0] d;
      rx = 1'b0;
      repeat (BIT / 3) @(negedge clk);
      rx = 1'b1;
      wait_bits(2);
      check_cnt++;
      if (dbg_state !== ST_IDLE || rx_ready !== 1'b0)
         $display("FAIL glitch_idle: got state %0d rdy %b expected %0d 0", dbg_state, rx_ready, ST_IDLE);
      else pass_cnt++;
      io_read(A_STAT, d);
      check_cnt++;
      if (d !== model_stat()) $display("FAIL glitch_stat: got %h expected %h", d, model_stat());
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [15:0] d;
      send_byte(8'($urandom_range(0, 255)));
      send_byte(8'($urandom_range(0, 255)));
      // Start 0xC4 (LSB first 0,0,1,...) and reset while bit 2 (high) is on the line.
      rx = 1'b0;
      wait_bits(3);
      rx = 1'b1;
      repeat (BIT / 2) @(negedge clk);
      check_cnt++;
      if (dbg_state !== ST_DATA) $display("FAIL midreset_in_data: got %0d expected %0d", dbg_state, ST_DATA);
      else pass_cnt++;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      m_ovf = 1'b0;
      m_ferr = 1'b0;
      wait_bits(12);
      check_cnt++;
      if (rx_ready !== 1'b0) $display("FAIL midreset_rdy: got %b expected 0", rx_ready);
      else pass_cnt++;
      io_read(A_STAT, d);
      check_cnt++;
      if (d !== 16'h0000) $display("FAIL midreset_stat: got %h expected 0000", d);
      else pass_cnt++;
      send_byte(8'h12);
      io_read(A_DATA, d);
      check_cnt++;
      if (d !== 16'h0012) $display("FAIL midreset_next: got %h expected 0012", d);
      else pass_cnt++;
      void'(exp_q.pop_front());
   endtask

   task automatic test_random();
      logic [15:0] d, e;
      int          n;
      for (int r = 0; r < 2; r++) begin
         n = $urandom_range(4, 20);
         for (int i = 0; i < n; i++) begin
            send_byte(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 40)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
               io_read(A_DATA, d);
               e = (exp_q.size() != 0) ? {8'h00, exp_q.pop_front()} : 16'h0000;
               check_cnt++;
               if (d !== e) $display("FAIL rand_mid_read: got %h expected %h", d, e);
               else pass_cnt++;
            end
         end
         io_read(A_STAT, d);
         e = model_stat();
         m_ovf = 1'b0;
         m_ferr = 1'b0;
         check_cnt++;
         if (d !== e) $display("FAIL rand_stat: got %h expected %h", d, e);
         else pass_cnt++;
         while (exp_q.size() != 0) begin
            io_read(A_DATA, d);
            e = {8'h00, exp_q.pop_front()};
            check_cnt++;
            if (d !== e) $display("FAIL rand_drain: got %h expected %h", d, e);
            else pass_cnt++;
         end
         io_read(A_DATA, d);
         check_cnt++;
         if (d !== 16'h0000 || rx_ready !== 1'b0)
            $display("FAIL rand_empty: got %h rdy %b expected 0000 0", d, rx_ready);
         else pass_cnt++;
      end
   endtask

   initial begin
      reset     = 1'b1;
      rx        = 1'b1;
      io_rd     = 1'b0;
      mem_addr  = 16'h0000;
      m_ovf     = 1'b0;
      m_ferr    = 1'b0;
      check_cnt = 0;
      pass_cnt  = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_two_bytes();
      test_overflow();
      test_framing();
      test_glitch();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
